// File: rtl/frame_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : frame_ram_arbiter
// Description : Lock-on-grant round-robin arbiter sharing the single-port frame
//               RAM between ACQ, PRC and RDO, with optional hold limit and
//               tagged read returns.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_ram_arbiter #(
    parameter int NB_ADC   = 12,
    parameter int NB_ADDR  = 10,
    parameter int MAX_HOLD = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_acq_req,
    input  logic               i_prc_req,
    input  logic               i_rdo_req,
    input  logic               i_acq_en,
    input  logic               i_prc_en,
    input  logic               i_rdo_en,
    input  logic               i_acq_we,
    input  logic               i_prc_we,
    input  logic               i_rdo_we,
    input  logic [NB_ADDR-1:0] i_acq_addr,
    input  logic [NB_ADDR-1:0] i_prc_addr,
    input  logic [NB_ADDR-1:0] i_rdo_addr,
    input  logic [NB_ADC-1:0]  i_acq_wdata,
    input  logic [NB_ADC-1:0]  i_prc_wdata,
    input  logic [NB_ADC-1:0]  i_rdo_wdata,
    output logic               o_acq_gnt,
    output logic               o_prc_gnt,
    output logic               o_rdo_gnt,
    output logic               o_acq_rvalid,
    output logic               o_prc_rvalid,
    output logic               o_rdo_rvalid,
    output logic [NB_ADC-1:0]  o_rdata,
    output logic               o_ram_en,
    output logic               o_ram_we,
    output logic [NB_ADDR-1:0] o_ram_addr,
    output logic [NB_ADC-1:0]  o_ram_wdata,
    input  logic [NB_ADC-1:0]  i_ram_rdata,
    output logic [1:0]         o_owner,
    output logic               o_busy
);

    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(MAX_HOLD);

    // State encoding doubles as the o_owner code.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_ACQ = 2'd1,
        OWN_PRC = 2'd2,
        OWN_RDO = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [2:0]          rvalid_q, rvalid_d;
    logic [NB_ADDR-1:0]  addr_q, addr_d;
    logic [NB_ADC-1:0]   wdata_q, wdata_d;

    logic [3:0]          req_vec;
    logic                own_gnt, own_req, own_en, own_we;
    logic [NB_ADDR-1:0]  own_addr;
    logic [NB_ADC-1:0]   own_wdata;
    logic [1:0]          own_idx;
    logic                ram_en;
    logic                win_valid;
    logic [1:0]          win_idx;
    int                  cand;
    logic [HOLD_W-1:0]   hold_inc;
    logic                others_req;
    logic                hold_fire;

    assign req_vec = {1'b0, i_rdo_req, i_prc_req, i_acq_req};

    always_comb begin
        own_gnt   = 1'b0;
        own_req   = 1'b0;
        own_en    = 1'b0;
        own_we    = 1'b0;
        own_addr  = i_acq_addr;
        own_wdata = i_acq_wdata;
        own_idx   = 2'd0;
        case (state_q)
            OWN_ACQ: begin
                own_gnt = gnt_q[0]; own_req = i_acq_req; own_en = i_acq_en;
                own_we  = i_acq_we; own_addr = i_acq_addr; own_wdata = i_acq_wdata;
                own_idx = 2'd0;
            end
            OWN_PRC: begin
                own_gnt = gnt_q[1]; own_req = i_prc_req; own_en = i_prc_en;
                own_we  = i_prc_we; own_addr = i_prc_addr; own_wdata = i_prc_wdata;
                own_idx = 2'd1;
            end
            OWN_RDO: begin
                own_gnt = gnt_q[2]; own_req = i_rdo_req; own_en = i_rdo_en;
                own_we  = i_rdo_we; own_addr = i_rdo_addr; own_wdata = i_rdo_wdata;
                own_idx = 2'd2;
            end
            default: ;
        endcase
    end

    // En is honoured only while the owner still holds its request.
    assign ram_en      = own_gnt & own_req & own_en;
    assign o_ram_en    = ram_en;
    assign o_ram_we    = ram_en & own_we;
    assign o_ram_addr  = ram_en ? own_addr  : addr_q;
    assign o_ram_wdata = ram_en ? own_wdata : wdata_q;
    assign addr_d      = o_ram_addr;
    assign wdata_d     = o_ram_wdata;
    assign rvalid_d    = (ram_en && !own_we) ? gnt_q : 3'b000;

    // Round-robin search starting at rr_ptr_q, the highest-priority master.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 0;
        for (int k = 0; k < 3; k++) begin
            cand = (int'(rr_ptr_q) + k) % 3;
            if (!win_valid && req_vec[cand[1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[1:0];
            end
        end
    end

    // Counter saturates so a long uncontested hold cannot wrap past the limit.
    assign hold_inc   = (hold_q == C_HOLD_MAX) ? hold_q : HOLD_W'(hold_q + 1'b1);
    assign others_req = |(req_vec[2:0] & ~(3'b001 << own_idx));
    assign hold_fire  = (MAX_HOLD > 0) && (hold_inc == C_HOLD_MAX) && others_req;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        if (state_q == IDLE) begin
            hold_d = '0;
            if (win_valid) begin
                state_d = state_t'(win_idx + 2'd1);
                gnt_d   = 3'b001 << win_idx;
            end
        end else begin
            hold_d = hold_inc;
            if (!own_req || hold_fire) begin
                state_d  = IDLE;
                gnt_d    = 3'b000;
                hold_d   = '0;
                rr_ptr_d = (own_idx == 2'd2) ? 2'd0 : own_idx + 2'd1;
            end
        end
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= 3'b000;
            busy_q   <= 1'b0;
            rr_ptr_q <= 2'd0;
            hold_q   <= '0;
            rvalid_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign o_acq_gnt    = gnt_q[0];
    assign o_prc_gnt    = gnt_q[1];
    assign o_rdo_gnt    = gnt_q[2];
    assign o_acq_rvalid = rvalid_q[0];
    assign o_prc_rvalid = rvalid_q[1];
    assign o_rdo_rvalid = rvalid_q[2];
    assign o_rdata      = i_ram_rdata;
    assign o_owner      = state_q;
    assign o_busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_ram_arbiter
// Description : Directed bench for frame_ram_arbiter with a sync-read RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        acq_req, prc_req, rdo_req;
    logic        acq_en, prc_en, rdo_en;
    logic        acq_we, prc_we, rdo_we;
    logic [9:0]  acq_addr, prc_addr, rdo_addr;
    logic [11:0] acq_wdata, prc_wdata, rdo_wdata;
    logic        acq_gnt, prc_gnt, rdo_gnt;
    logic        acq_rvalid, prc_rvalid, rdo_rvalid;
    logic [11:0] rdata;
    logic        ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata = '0;
    logic [1:0]  owner;
    logic        busy;

    logic [11:0]   mem [0:1023];
    logic [1023:0] written = '0;

    int n_vec = 0;
    int n_err = 0;

    frame_ram_arbiter #(
        .NB_ADC  (12),
        .NB_ADDR (10),
        .MAX_HOLD(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_acq_req   (acq_req),
        .i_prc_req   (prc_req),
        .i_rdo_req   (rdo_req),
        .i_acq_en    (acq_en),
        .i_prc_en    (prc_en),
        .i_rdo_en    (rdo_en),
        .i_acq_we    (acq_we),
        .i_prc_we    (prc_we),
        .i_rdo_we    (rdo_we),
        .i_acq_addr  (acq_addr),
        .i_prc_addr  (prc_addr),
        .i_rdo_addr  (rdo_addr),
        .i_acq_wdata (acq_wdata),
        .i_prc_wdata (prc_wdata),
        .i_rdo_wdata (rdo_wdata),
        .o_acq_gnt   (acq_gnt),
        .o_prc_gnt   (prc_gnt),
        .o_rdo_gnt   (rdo_gnt),
        .o_acq_rvalid(acq_rvalid),
        .o_prc_rvalid(prc_rvalid),
        .o_rdo_rvalid(rdo_rvalid),
        .o_rdata     (rdata),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_owner     (owner),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten words read back as addr ^ 0x5A5.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= written[ram_addr] ? mem[ram_addr] : (12'h5A5 ^ {2'b00, ram_addr});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        {acq_req, prc_req, rdo_req} = '0;
        {acq_en, prc_en, rdo_en}    = '0;
        {acq_we, prc_we, rdo_we}    = '0;
        acq_addr = '0; prc_addr = '0; rdo_addr = '0;
        acq_wdata = '0; prc_wdata = '0; rdo_wdata = '0;
        repeat (2) cyc();
        chk("rst_gnt",    {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'd0);
        chk("rst_rvalid", {29'd0, rdo_rvalid, prc_rvalid, acq_rvalid}, 32'd0);
        chk("rst_owner",  {30'd0, owner}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_ram_en", {30'd0, ram_en, ram_we}, 32'd0);
        chk("rst_addr",   {22'd0, ram_addr}, 32'd0);
        chk("rst_wdata",  {20'd0, ram_wdata}, 32'd0);
        rst = 1'b1;

        // PRC alone: write 0xABC to 5, then read it back
        prc_req = 1'b1;
        cyc();
        chk("t1_prc_gnt", {31'd0, prc_gnt}, 32'd1);
        chk("t1_acq_gnt", {31'd0, acq_gnt}, 32'd0);
        chk("t1_owner",   {30'd0, owner}, 32'd2);
        chk("t1_busy",    {31'd0, busy}, 32'd1);
        prc_en = 1'b1; prc_we = 1'b1; prc_addr = 10'd5; prc_wdata = 12'hABC;
        #1;
        chk("t1_wr_en",    {31'd0, ram_en}, 32'd1);
        chk("t1_wr_we",    {31'd0, ram_we}, 32'd1);
        chk("t1_wr_addr",  {22'd0, ram_addr}, 32'd5);
        chk("t1_wr_wdata", {20'd0, ram_wdata}, 32'hABC);
        cyc();
        prc_we = 1'b0;
        #1;
        chk("t1_rd_en", {31'd0, ram_en}, 32'd1);
        chk("t1_rd_we", {31'd0, ram_we}, 32'd0);
        cyc();
        prc_en = 1'b0;
        #1;
        chk("t1_prc_rvalid", {31'd0, prc_rvalid}, 32'd1);
        chk("t1_rdata",      {20'd0, rdata}, 32'hABC);
        chk("t1_acq_rvalid", {31'd0, acq_rvalid}, 32'd0);
        chk("t1_idle_en",    {31'd0, ram_en}, 32'd0);
        chk("t1_addr_hold",  {22'd0, ram_addr}, 32'd5);
        prc_req = 1'b0;
        cyc();
        chk("t1_rel_gnt",    {31'd0, prc_gnt}, 32'd0);
        chk("t1_rel_owner",  {30'd0, owner}, 32'd0);
        chk("t1_rel_rvalid", {31'd0, prc_rvalid}, 32'd0);

        // Fresh reset, three simultaneous requests
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        acq_req = 1'b1; prc_req = 1'b1; rdo_req = 1'b1;
        cyc();
        chk("t2_first_gnt", {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b001);
        chk("t2_owner_acq", {30'd0, owner}, 32'd1);
        cyc();
        chk("t2_acq_hold", {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b001);
        acq_req = 1'b0;
        cyc();
        chk("t2_dead1_gnt",   {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b000);
        chk("t2_dead1_owner", {30'd0, owner}, 32'd0);
        chk("t2_dead1_busy",  {31'd0, busy}, 32'd0);
        cyc();
        chk("t2_prc_gnt",   {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b010);
        chk("t2_owner_prc", {30'd0, owner}, 32'd2);
        prc_req = 1'b0;
        cyc();
        chk("t2_dead2_gnt", {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b000);
        cyc();
        chk("t2_rdo_gnt",   {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b100);
        chk("t2_owner_rdo", {30'd0, owner}, 32'd3);

        // RDO reads in its last cycle while ACQ waits
        acq_req = 1'b1;
        rdo_en = 1'b1; rdo_we = 1'b0; rdo_addr = 10'd5;
        #1;
        chk("t3_rd_en",   {31'd0, ram_en}, 32'd1);
        chk("t3_rd_addr", {22'd0, ram_addr}, 32'd5);
        cyc();
        rdo_en = 1'b0; rdo_req = 1'b0;
        #1;
        chk("t3_rdo_rvalid", {31'd0, rdo_rvalid}, 32'd1);
        chk("t3_rdata",      {20'd0, rdata}, 32'hABC);
        chk("t3_acq_rvalid", {31'd0, acq_rvalid}, 32'd0);
        chk("t3_prc_rvalid", {31'd0, prc_rvalid}, 32'd0);
        cyc();
        chk("t3_dead_gnt",    {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b000);
        chk("t3_rvalid_done", {31'd0, rdo_rvalid}, 32'd0);
        cyc();
        chk("t3_acq_gnt", {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b001);

        // Hold limit of 4 with PRC waiting
        prc_req = 1'b1;
        cyc();
        chk("t4_hold_c2", {31'd0, acq_gnt}, 32'd1);
        cyc();
        chk("t4_hold_c3", {31'd0, acq_gnt}, 32'd1);
        cyc();
        chk("t4_hold_c4", {31'd0, acq_gnt}, 32'd1);
        cyc();
        chk("t4_forced_rel", {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b000);
        cyc();
        chk("t4_prc_after", {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b010);
        chk("t4_owner",     {30'd0, owner}, 32'd2);

        // ACQ strobes without a grant while PRC owns the RAM
        acq_en = 1'b1; acq_we = 1'b1; acq_addr = 10'd7; acq_wdata = 12'hFFF;
        #1;
        chk("t5_ignore_en",   {31'd0, ram_en}, 32'd0);
        chk("t5_ignore_we",   {31'd0, ram_we}, 32'd0);
        chk("t5_addr_hold",   {22'd0, ram_addr}, 32'd5);
        cyc();
        chk("t5_no_acq_regnt", {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b010);
        prc_en = 1'b1; prc_we = 1'b0; prc_addr = 10'd7;
        #1;
        chk("t5_rd_en",   {31'd0, ram_en}, 32'd1);
        chk("t5_rd_we",   {31'd0, ram_we}, 32'd0);
        chk("t5_rd_addr", {22'd0, ram_addr}, 32'd7);
        cyc();
        prc_en = 1'b0; prc_req = 1'b0;
        acq_en = 1'b0; acq_we = 1'b0; acq_req = 1'b0;
        #1;
        chk("t5_prc_rvalid", {31'd0, prc_rvalid}, 32'd1);
        chk("t5_word7",      {20'd0, rdata}, 32'h5A2);
        chk("t5_acq_rvalid", {31'd0, acq_rvalid}, 32'd0);
        cyc();
        chk("t5_idle", {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b000);

        // Async reset in the middle of a PRC write burst
        prc_req = 1'b1;
        cyc();
        chk("t6_prc_gnt", {31'd0, prc_gnt}, 32'd1);
        prc_en = 1'b1; prc_we = 1'b0; prc_addr = 10'd5;
        cyc();
        prc_we = 1'b1; prc_addr = 10'd10; prc_wdata = 12'h123;
        #1;
        chk("t6_pre_rvalid", {31'd0, prc_rvalid}, 32'd1);
        chk("t6_pre_wr_en",  {30'd0, ram_en, ram_we}, 32'b11);
        #2;
        rst = 1'b0;
        acq_req = 1'b1; rdo_req = 1'b1;
        #1;
        chk("t6_async_gnt",    {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b000);
        chk("t6_async_rvalid", {29'd0, rdo_rvalid, prc_rvalid, acq_rvalid}, 32'b000);
        chk("t6_async_ram_en", {31'd0, ram_en}, 32'd0);
        chk("t6_async_owner",  {30'd0, owner}, 32'd0);
        chk("t6_async_busy",   {31'd0, busy}, 32'd0);
        cyc();
        chk("t6_no_write", {31'd0, written[10]}, 32'd0);
        rst = 1'b1;
        cyc();
        chk("t6_reset_prio", {29'd0, rdo_gnt, prc_gnt, acq_gnt}, 32'b001);
        chk("t6_owner",      {30'd0, owner}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
